// File: rtl/cla_pkg.sv
// cla_pkg: shared FSM state encoding and nibble-count helper for the CLA scheduler
package cla_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nibbles(input int width);
    return width / 4;
  endfunction
endpackage

// File: rtl/cla4_slice.sv
// cla4_slice: 4-bit carry-lookahead adder; a, b, cin in; sum, cout out
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p, g;
  logic [4:0] c;
  assign p = a ^ b;
  assign g = a & b;
  assign c[0] = cin;
  assign c[1] = g[0] | p[0] & cin;
  assign c[2] = g[1] | p[1] & g[0] | p[1] & p[0] & cin;
  assign c[3] = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & cin;
  assign c[4] = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0]
              | p[3] & p[2] & p[1] & p[0] & cin;
  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/cla_add_scheduler.sv
// cla_add_scheduler: two requesters share one 4-bit CLA slice, adding nibble-serially
// ports: req_i/gnt_o handshake, a*/b*/cin* operands, done_o/ack_i result handshake, sum_o/cout_o result
module cla_add_scheduler
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic             cin0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  input  logic             cin1_i,
  output logic [1:0]       gnt_o,
  output logic             busy_o,
  output logic [1:0]       done_o,
  input  logic [1:0]       ack_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  localparam int NIB = nibbles(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [3:0]       cnt, s;
  logic             carry, owner, co, win;
  // owner doubles as last_grant: it keeps the previous winner until the next capture
  assign win    = &req_i ? ~owner : req_i[1];
  assign busy_o = state != IDLE;
  assign sum_o  = state == DONE ? sum_q : '0;
  assign cout_o = state == DONE & carry;
  cla4_slice u_slice (.a(a_q[3:0]), .b(b_q[3:0]), .cin(carry), .sum(s), .cout(co));
  // operands shift down so the slice always sees nibble 0; result nibbles enter at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      owner  <= 1'b1;
      cnt    <= '0;
      gnt_o  <= '0;
      done_o <= '0;
    end else begin
      gnt_o <= '0;
      case (state)
        IDLE: if (|req_i) begin
          state <= RUN;
          owner <= win;
          a_q   <= win ? a1_i : a0_i;
          b_q   <= win ? b1_i : b0_i;
          carry <= win ? cin1_i : cin0_i;
          cnt   <= '0;
          gnt_o <= win ? 2'b10 : 2'b01;
        end
        RUN: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          carry <= co;
          sum_q <= (sum_q >> 4) | (WIDTH'(s) << (WIDTH - 4));
          cnt   <= cnt + 4'd1;
          if (cnt == 4'(NIB - 1)) begin
            state  <= DONE;
            done_o <= owner ? 2'b10 : 2'b01;
          end
        end
        DONE: if (ack_i[owner]) begin
          state  <= IDLE;
          done_o <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_add_scheduler.sv
// tb_cla_add_scheduler: randomized self-checking bench against an arithmetic reference model
module tb_cla_add_scheduler;
  logic        clk = 0, rst_n = 0;
  logic [1:0]  req_i = 0, ack_i = 0;
  logic [15:0] a0_i = 0, b0_i = 0, a1_i = 0, b1_i = 0;
  logic        cin0_i = 0, cin1_i = 0;
  logic [1:0]  gnt_o, done_o;
  logic        busy_o, cout_o;
  logic [15:0] sum_o;
  int          checks = 0, errors = 0;
  logic        last = 1'b1;
  always #5 clk = ~clk;
  cla_add_scheduler #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i),
    .a0_i(a0_i), .b0_i(b0_i), .cin0_i(cin0_i),
    .a1_i(a1_i), .b1_i(b1_i), .cin1_i(cin1_i),
    .gnt_o(gnt_o), .busy_o(busy_o), .done_o(done_o), .ack_i(ack_i),
    .sum_o(sum_o), .cout_o(cout_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic zero_outs(input string tag);
    chk({tag, "_gnt"}, gnt_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_sum"}, sum_o, 0);
    chk({tag, "_cout"}, cout_o, 0);
  endtask
  task automatic rand_ops();
    a0_i = 16'($urandom); b0_i = 16'($urandom); cin0_i = 1'($urandom);
    a1_i = 16'($urandom); b1_i = 16'($urandom); cin1_i = 1'($urandom);
  endtask
  task automatic wait_gnt(input logic [1:0] eg, input string tag);
    logic pb;
    pb = busy_o;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt_o != 0) break;
      pb = busy_o;
    end
    chk({tag, "_gnt"}, gnt_o, eg);
    chk({tag, "_idle_before_gnt"}, pb, 0);
  endtask
  task automatic wait_done(input logic [1:0] eg, input logic [16:0] e, input string tag);
    int n = 0;
    while (done_o == 0 && n < 20) begin
      chk({tag, "_res_hidden"}, {cout_o, sum_o}, 0);
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_done"}, done_o, eg);
    chk({tag, "_sum"}, sum_o, e[15:0]);
    chk({tag, "_cout"}, cout_o, e[16]);
  endtask
  task automatic job(input logic [1:0] rq, input logic [15:0] a, input logic [15:0] b,
                     input logic c, input bit hold, input string tag,
                     output logic [1:0] eg, output logic [16:0] e);
    eg = rq == 2'b11 ? (last ? 2'b01 : 2'b10) : rq;
    last = eg[1];
    rand_ops();
    if (eg[0]) begin a0_i = a; b0_i = b; cin0_i = c; end
    else begin a1_i = a; b1_i = b; cin1_i = c; end
    e = 17'(a) + 17'(b) + 17'(c);
    req_i = rq;
    wait_gnt(eg, tag);
    if (!hold) req_i = 0;
    rand_ops();
    wait_done(eg, e, tag);
  endtask
  task automatic finish_job(input logic [1:0] eg, input string tag);
    ack_i = eg;
    @(negedge clk);
    ack_i = 0;
    chk({tag, "_ack_done"}, done_o, 0);
    chk({tag, "_ack_busy"}, busy_o, 0);
    chk({tag, "_ack_gnt"}, gnt_o, 0);
  endtask
  initial begin
    logic [1:0]  eg;
    logic [16:0] e;
    repeat (2) @(negedge clk);
    zero_outs("reset");
    rst_n = 1;
    job(2'b01, 16'h1234, 16'h4321, 1'b0, 0, "basic", eg, e);
    chk("basic_sum_const", sum_o, 16'h5555);
    ack_i = 2'b10;
    repeat (2) @(negedge clk);
    chk("wrong_ack_done", done_o, 2'b01);
    chk("wrong_ack_sum", sum_o, 16'h5555);
    finish_job(eg, "basic");
    job(2'b10, 16'hFFFF, 16'h0001, 1'b0, 0, "ovf_c0", eg, e);
    chk("ovf_c0_const", {cout_o, sum_o}, 17'h10000);
    finish_job(eg, "ovf_c0");
    job(2'b10, 16'hFFFF, 16'h0001, 1'b1, 0, "ovf_c1", eg, e);
    chk("ovf_c1_const", {cout_o, sum_o}, 17'h10001);
    finish_job(eg, "ovf_c1");
    job(2'b01, 16'hFFFF, 16'h0000, 1'b1, 0, "wrap", eg, e);
    chk("wrap_const", {cout_o, sum_o}, 17'h10000);
    finish_job(eg, "wrap");
    for (int i = 0; i < 4; i++) begin
      job(2'b11, 16'($urandom), 16'($urandom), 1'($urandom), 1, "rr", eg, e);
      chk("rr_alternate", eg, i % 2 ? 2'b01 : 2'b10);
      finish_job(eg, "rr");
    end
    req_i = 0;
    @(negedge clk);
    a0_i = 16'h0F0F; b0_i = 16'h00FF; cin0_i = 1'b1;
    req_i = 2'b01;
    wait_gnt(2'b01, "abort");
    req_i = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    last = 1'b1;
    #1;
    zero_outs("abort_rst");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_done", done_o, 0);
    end
    job(2'b11, 16'h0F0F, 16'h00FF, 1'b1, 0, "post_rst", eg, e);
    chk("post_rst_winner", eg, 2'b01);
    finish_job(eg, "post_rst");
    for (int i = 0; i < 1000; i++) begin
      job(2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom), 1'($urandom), 0, "sweep", eg, e);
      finish_job(eg, "sweep");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
